// File: rtl/fpro_bridge_multi.sv
// MCS IO bus to N-slot FPro bridge with per-slot ack, bus timeout
// and sticky error capture for unmapped or timed-out accesses.
module fpro_bridge_multi #(
    parameter logic [31:0]       BRG_BASE = 32'hc000_0000,
    parameter int                N_SLOT   = 4,
    parameter int                ADDR_W   = 20,
    parameter logic [N_SLOT-1:0] ACK_MASK = '0,
    parameter int                TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  io_addr_strobe,
    input  logic                  io_read_strobe,
    input  logic                  io_write_strobe,
    input  logic [3:0]            io_byte_enable,
    input  logic [31:0]           io_address,
    input  logic [31:0]           io_write_data,
    output logic [31:0]           io_read_data,
    output logic                  io_ready,
    output logic [N_SLOT-1:0]     fp_cs,
    output logic                  fp_rd,
    output logic                  fp_wr,
    output logic [ADDR_W-1:0]     fp_addr,
    output logic [31:0]           fp_wr_data,
    output logic [3:0]            fp_byte_en,
    input  logic [32*N_SLOT-1:0]  fp_rd_data,
    input  logic [N_SLOT-1:0]     fp_ack,
    input  logic                  err_clr,
    output logic                  err,
    output logic [31:0]           err_addr
);

    localparam int S = $clog2(N_SLOT);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [S-1:0]  slot_q, slot_d;
    logic          wr_q, wr_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [31:0]   err_addr_q, err_addr_d;

    logic          strobe;
    logic          hit;
    logic          set_err;
    logic [31:0]   err_src;
    logic [31:0]   sel_data;
    logic          unused_addr_strobe;

    assign unused_addr_strobe = io_addr_strobe;
    assign strobe   = io_read_strobe | io_write_strobe;
    assign hit      = (io_address[31:24] == BRG_BASE[31:24]);
    assign sel_data = fp_rd_data[32*slot_q +: 32];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        set_err    = 1'b0;
        err_src    = addr_q;
        unique case (state_q)
            IDLE: begin
                if (strobe) begin
                    slot_d  = io_address[23 -: S];
                    wr_d    = io_write_strobe;
                    addr_d  = io_address;
                    wdata_d = io_write_data;
                    be_d    = io_byte_enable;
                    if (hit) begin
                        state_d = ACCESS;
                    end else begin
                        state_d = RESP;
                        set_err = 1'b1;
                        err_src = io_address;
                        if (!io_write_strobe) rdata_d = '1;
                    end
                end
            end
            ACCESS: begin
                cnt_d = '0;
                if (!ACK_MASK[slot_q] || fp_ack[slot_q]) begin
                    if (!wr_q) rdata_d = sel_data;
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (fp_ack[slot_q]) begin
                    if (!wr_q) rdata_d = sel_data;
                    state_d = RESP;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    if (!wr_q) rdata_d = '1;
                    set_err = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        // only the first error since the last clear records its address
        if (set_err) begin
            err_d = 1'b1;
            if (!err_q) err_addr_d = err_src;
        end
        if (err_clr) begin
            err_d      = 1'b0;
            err_addr_d = '0;
        end
    end

    always_comb begin
        fp_cs    = '0;
        fp_rd    = 1'b0;
        fp_wr    = 1'b0;
        io_ready = 1'b0;
        unique case (state_q)
            IDLE: ;
            ACCESS: begin
                fp_cs = N_SLOT'(1) << slot_q;
                fp_rd = !wr_q;
                fp_wr = wr_q;
            end
            WAIT: fp_cs = N_SLOT'(1) << slot_q;
            RESP: io_ready = 1'b1;
        endcase
    end

    assign io_read_data = rdata_q;
    assign fp_addr      = addr_q[ADDR_W+1:2];
    assign fp_wr_data   = wdata_q;
    assign fp_byte_en   = be_q;
    assign err          = err_q;
    assign err_addr     = err_addr_q;

endmodule

// File: tb/tb_fpro_bridge_multi.sv
// Randomised bench for fpro_bridge_multi against a transaction-level
// model of latency, read data and sticky error state.
module tb_fpro_bridge_multi;

    localparam int         NS    = 4;
    localparam int         AW    = 20;
    localparam int         TO    = 8;
    localparam logic [3:0] AMASK = 4'b1100;

    logic          clk = 1'b0;
    logic          reset;
    logic          io_addr_strobe, io_read_strobe, io_write_strobe;
    logic [3:0]    io_byte_enable;
    logic [31:0]   io_address, io_write_data, io_read_data;
    logic          io_ready;
    logic [NS-1:0] fp_cs;
    logic          fp_rd, fp_wr;
    logic [AW-1:0] fp_addr;
    logic [31:0]   fp_wr_data;
    logic [3:0]    fp_byte_en;
    logic [32*NS-1:0] fp_rd_data;
    logic [NS-1:0] fp_ack;
    logic          err_clr, err;
    logic [31:0]   err_addr;

    logic [31:0]   slot_data [NS];
    assign fp_rd_data = {slot_data[3], slot_data[2], slot_data[1], slot_data[0]};

    fpro_bridge_multi #(
        .BRG_BASE(32'hc000_0000), .N_SLOT(NS), .ADDR_W(AW),
        .ACK_MASK(AMASK), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
        .io_write_strobe(io_write_strobe), .io_byte_enable(io_byte_enable),
        .io_address(io_address), .io_write_data(io_write_data),
        .io_read_data(io_read_data), .io_ready(io_ready),
        .fp_cs(fp_cs), .fp_rd(fp_rd), .fp_wr(fp_wr), .fp_addr(fp_addr),
        .fp_wr_data(fp_wr_data), .fp_byte_en(fp_byte_en),
        .fp_rd_data(fp_rd_data), .fp_ack(fp_ack),
        .err_clr(err_clr), .err(err), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_rdata;
    logic        m_err;
    logic [31:0] m_err_addr;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
    endtask

    task automatic clr_err;
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        m_err = 1'b0;
        m_err_addr = '0;
        chk("clr_err", {31'd0, err}, 32'd0);
        chk("clr_err_addr", err_addr, 32'd0);
    endtask

    // ack_at: cycle after the strobe in which the slot acks (0 = never)
    task automatic xact(input logic [31:0] addr, input logic wr,
                        input logic [31:0] wd, input logic [3:0] be,
                        input int ack_at, input bit noise);
        logic       hit, ackslot, fault;
        int         slot, lat, c;
        logic [3:0] av;
        hit     = (addr[31:24] == 8'hc0);
        slot    = int'(addr[23:22]);
        ackslot = hit && AMASK[slot];
        fault   = !hit || (ackslot && (ack_at < 1 || ack_at > TO + 1));
        if (!hit)                 lat = 1;
        else if (!ackslot)        lat = 2;
        else if (!fault)          lat = ack_at + 1;
        else                      lat = TO + 2;
        if (!wr) m_rdata = fault ? 32'hFFFF_FFFF : slot_data[slot];
        if (fault) begin
            if (!m_err) m_err_addr = addr;
            m_err = 1'b1;
        end
        io_address      = addr;
        io_write_data   = wd;
        io_byte_enable  = be;
        io_write_strobe = wr;
        io_read_strobe  = wr ? 1'($urandom % 2) : 1'b1;
        io_addr_strobe  = 1'b1;
        tick;
        idle_in;
        c = 1;
        while (c <= 20) begin
            if (hit && c == 1) begin
                chk("cs_acc", {28'd0, fp_cs}, 32'd1 << slot);
                chk("rd_acc", {31'd0, fp_rd}, {31'd0, !wr});
                chk("wr_acc", {31'd0, fp_wr}, {31'd0, wr});
                chk("fp_addr", {12'd0, fp_addr}, {12'd0, addr[21:2]});
                chk("wr_data", fp_wr_data, wd);
                chk("byte_en", {28'd0, fp_byte_en}, {28'd0, be});
            end
            if (hit && c > 1 && c < lat) begin
                chk("cs_wait", {28'd0, fp_cs}, 32'd1 << slot);
                chk("rdwr_wait", {30'd0, fp_rd, fp_wr}, 32'd0);
            end
            if (io_ready) break;
            av = noise ? 4'($urandom) : 4'd0;
            if (ackslot) av[slot] = (c == ack_at);
            fp_ack = av;
            if (noise && ($urandom % 4 == 0)) begin
                io_address     = $urandom;
                io_read_strobe = 1'b1;
            end
            tick;
            idle_in;
            c++;
        end
        fp_ack = '0;
        chk("latency", 32'(c), 32'(lat));
        chk("cs_resp", {28'd0, fp_cs}, 32'd0);
        chk("rdata", io_read_data, m_rdata);
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("err_addr", err_addr, m_err_addr);
        tick;
        chk("ready_pulse", {31'd0, io_ready}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        idle_in;
        io_byte_enable = '0;
        io_address = '0;
        io_write_data = '0;
        fp_ack = '0;
        err_clr = 1'b0;
        for (int i = 0; i < NS; i++) slot_data[i] = '0;
        m_rdata = '0;
        m_err = 1'b0;
        m_err_addr = '0;
        tick;
        tick;
        chk("rst_ready", {31'd0, io_ready}, 32'd0);
        chk("rst_cs", {28'd0, fp_cs}, 32'd0);
        chk("rst_rdwr", {30'd0, fp_rd, fp_wr}, 32'd0);
        chk("rst_rdata", io_read_data, 32'd0);
        chk("rst_addr", {12'd0, fp_addr}, 32'd0);
        chk("rst_wdata", fp_wr_data, 32'd0);
        chk("rst_be", {28'd0, fp_byte_en}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        reset = 1'b0;
        tick;

        slot_data[0] = 32'h1234_5678;
        xact(32'hc000_0010, 1'b0, 32'd0, 4'hf, 0, 1'b0);
        xact(32'hc040_0008, 1'b1, 32'hA5A5_0001, 4'b0011, 0, 1'b0);
        slot_data[2] = 32'hCAFE_0002;
        xact(32'hc080_0000, 1'b0, 32'd0, 4'hf, 5, 1'b0);
        xact(32'hc0c0_0004, 1'b0, 32'd0, 4'hf, 0, 1'b0);
        xact(32'hc080_0100, 1'b0, 32'd0, 4'hf, 0, 1'b0);
        clr_err;
        xact(32'h8000_0000, 1'b0, 32'd0, 4'hf, 0, 1'b0);
        clr_err;

        // error set and clear in the same cycle: clear wins
        io_address = 32'h1234_0000;
        io_read_strobe = 1'b1;
        err_clr = 1'b1;
        tick;
        idle_in;
        err_clr = 1'b0;
        m_rdata = 32'hFFFF_FFFF;
        chk("clr_prio_err", {31'd0, err}, 32'd0);
        chk("clr_prio_addr", err_addr, 32'd0);
        chk("clr_prio_ready", {31'd0, io_ready}, 32'd1);
        chk("clr_prio_rdata", io_read_data, m_rdata);
        tick;

        // reset while waiting on an ack slot
        io_address = 32'hc0c0_0000;
        io_read_strobe = 1'b1;
        tick;
        idle_in;
        tick;
        tick;
        chk("pre_rst_cs", {28'd0, fp_cs}, 32'd8);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        m_rdata = '0;
        m_err = 1'b0;
        m_err_addr = '0;
        chk("mid_rst_cs", {28'd0, fp_cs}, 32'd0);
        chk("mid_rst_ready", {31'd0, io_ready}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            if (io_ready) chk("post_rst_ready", 32'd1, 32'd0);
            tick;
        end
        slot_data[1] = 32'h0BAD_F00D;
        xact(32'hc040_0020, 1'b0, 32'd0, 4'hf, 0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom % 5 != 0) a[31:24] = 8'hc0;
            else if (a[31:24] == 8'hc0) a[31:24] = 8'h00;
            for (int i = 0; i < NS; i++) slot_data[i] = $urandom;
            if ($urandom % 12 == 0) clr_err;
            xact(a, 1'($urandom % 2), $urandom, 4'($urandom),
                 int'($urandom_range(0, 12)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
